// File: rtl/cache_line_sequencer.sv
// Moves whole cache lines between the cache data array and an AXI4 memory port:
// an optional dirty-line writeback burst, then an optional refill burst, one request at a time.
module cache_line_sequencer #(
    parameter int                  ID_WIDTH   = 6,
    parameter int                  LINE_BEATS = 4,
    parameter logic [ID_WIDTH-1:0] AXI_ID     = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_req_valid,
    output logic                          o_req_ready,
    input  logic                          i_req_wb,
    input  logic [31:0]                   i_req_wb_addr,
    input  logic                          i_req_fill,
    input  logic [31:0]                   i_req_fill_addr,
    output logic                          o_wb_rd_en,
    output logic [$clog2(LINE_BEATS)-1:0] o_wb_rd_beat,
    input  logic [63:0]                   i_wb_rd_data,
    output logic                          o_fill_we,
    output logic [$clog2(LINE_BEATS)-1:0] o_fill_beat,
    output logic [63:0]                   o_fill_data,
    output logic                          o_done,
    output logic                          o_err,
    output logic [ID_WIDTH-1:0]           o_awid,
    output logic [31:0]                   o_awaddr,
    output logic [7:0]                    o_awlen,
    output logic [2:0]                    o_awsize,
    output logic [1:0]                    o_awburst,
    output logic                          o_awvalid,
    input  logic                          i_awready,
    output logic [63:0]                   o_wdata,
    output logic [7:0]                    o_wstrb,
    output logic                          o_wlast,
    output logic                          o_wvalid,
    input  logic                          i_wready,
    input  logic [ID_WIDTH-1:0]           i_bid,
    input  logic [1:0]                    i_bresp,
    input  logic                          i_bvalid,
    output logic                          o_bready,
    output logic [ID_WIDTH-1:0]           o_arid,
    output logic [31:0]                   o_araddr,
    output logic [7:0]                    o_arlen,
    output logic [2:0]                    o_arsize,
    output logic [1:0]                    o_arburst,
    output logic                          o_arvalid,
    input  logic                          i_arready,
    input  logic [ID_WIDTH-1:0]           i_rid,
    input  logic [63:0]                   i_rdata,
    input  logic [1:0]                    i_rresp,
    input  logic                          i_rlast,
    input  logic                          i_rvalid,
    output logic                          o_rready
);
    localparam int                BEAT_W    = $clog2(LINE_BEATS);
    localparam logic [31:0]       LINE_MASK = ~(32'(LINE_BEATS * 8) - 32'd1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS - 1);

    typedef enum logic [2:0] {
        IDLE, WB_AW, WB_RD, WB_W, WB_B, FILL_AR, FILL_R, DONE
    } state_t;

    state_t            state_reg, state_next;
    logic [BEAT_W-1:0] beat_reg, beat_next;
    logic              err_reg, err_next;
    logic              fill_reg;
    logic [31:0]       wb_addr_reg;
    logic [31:0]       fill_addr_reg;
    logic              wfirst_reg;
    logic [63:0]       wdata_reg;
    logic              fill_we_reg;
    logic [BEAT_W-1:0] fill_beat_reg;
    logic [63:0]       fill_data_reg;
    logic              beat_last;

    // Response IDs carry no information for a single outstanding request.
    logic unused_ids;
    assign unused_ids = ^{i_bid, i_rid};

    assign beat_last = (beat_reg == LAST_BEAT);

    always_comb begin
        state_next = state_reg;
        beat_next  = beat_reg;
        err_next   = err_reg;
        case (state_reg)
            IDLE: begin
                if (i_req_valid) begin
                    err_next = 1'b0;
                    if (i_req_wb)
                        state_next = WB_AW;
                    else if (i_req_fill)
                        state_next = FILL_AR;
                    else
                        state_next = DONE;
                end
            end
            WB_AW: begin
                if (i_awready) begin
                    state_next = WB_RD;
                    beat_next  = '0;
                end
            end
            WB_RD: state_next = WB_W;
            WB_W: begin
                if (i_wready) begin
                    if (beat_last) begin
                        state_next = WB_B;
                    end else begin
                        beat_next  = beat_reg + 1'b1;
                        state_next = WB_RD;
                    end
                end
            end
            WB_B: begin
                if (i_bvalid) begin
                    if (i_bresp != 2'b00)
                        err_next = 1'b1;
                    state_next = fill_reg ? FILL_AR : DONE;
                end
            end
            FILL_AR: begin
                if (i_arready) begin
                    state_next = FILL_R;
                    beat_next  = '0;
                end
            end
            FILL_R: begin
                if (i_rvalid) begin
                    if (i_rresp != 2'b00 || i_rlast != beat_last)
                        err_next = 1'b1;
                    beat_next = beat_reg + 1'b1;
                    // Burst length is fixed; a misplaced rlast only flags an error.
                    if (beat_last)
                        state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            beat_reg      <= '0;
            err_reg       <= 1'b0;
            fill_reg      <= 1'b0;
            wb_addr_reg   <= '0;
            fill_addr_reg <= '0;
            wfirst_reg    <= 1'b0;
            wdata_reg     <= '0;
            fill_we_reg   <= 1'b0;
            fill_beat_reg <= '0;
            fill_data_reg <= '0;
        end else begin
            state_reg <= state_next;
            beat_reg  <= beat_next;
            err_reg   <= err_next;
            if (state_reg == IDLE && i_req_valid) begin
                fill_reg      <= i_req_fill;
                wb_addr_reg   <= i_req_wb_addr & LINE_MASK;
                fill_addr_reg <= i_req_fill_addr & LINE_MASK;
            end
            // Array read data is only valid in the first WB_W cycle; hold it afterwards.
            wfirst_reg <= (state_reg == WB_RD);
            if (wfirst_reg)
                wdata_reg <= i_wb_rd_data;
            fill_we_reg <= (state_reg == FILL_R) && i_rvalid;
            if (state_reg == FILL_R && i_rvalid) begin
                fill_beat_reg <= beat_reg;
                fill_data_reg <= i_rdata;
            end
        end
    end

    assign o_req_ready  = (state_reg == IDLE);
    assign o_wb_rd_en   = (state_reg == WB_RD);
    assign o_wb_rd_beat = beat_reg;
    assign o_fill_we    = fill_we_reg;
    assign o_fill_beat  = fill_beat_reg;
    assign o_fill_data  = fill_data_reg;
    assign o_done       = (state_reg == DONE);
    assign o_err        = (state_reg == DONE) && err_reg;

    assign o_awid    = AXI_ID;
    assign o_awaddr  = wb_addr_reg;
    assign o_awlen   = 8'(LINE_BEATS - 1);
    assign o_awsize  = 3'd3;
    assign o_awburst = 2'b01;
    assign o_awvalid = (state_reg == WB_AW);

    assign o_wdata  = wfirst_reg ? i_wb_rd_data : wdata_reg;
    assign o_wstrb  = 8'hFF;
    assign o_wlast  = (state_reg == WB_W) && beat_last;
    assign o_wvalid = (state_reg == WB_W);
    assign o_bready = (state_reg == WB_B);

    assign o_arid    = AXI_ID;
    assign o_araddr  = fill_addr_reg;
    assign o_arlen   = 8'(LINE_BEATS - 1);
    assign o_arsize  = 3'd3;
    assign o_arburst = 2'b01;
    assign o_arvalid = (state_reg == FILL_AR);
    assign o_rready  = (state_reg == FILL_R);

endmodule

// File: tb/tb_cache_line_sequencer.sv
// Randomized scoreboard bench: an AXI slave plus data-array model answer the sequencer,
// and a line-level memory model predicts every burst, fill write and completion status.
module tb_cache_line_sequencer;
    localparam int IDW = 6;
    localparam int LB  = 4;
    localparam int BW  = $clog2(LB);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic           i_req_valid = 0, i_req_wb = 0, i_req_fill = 0;
    logic [31:0]    i_req_wb_addr = 0, i_req_fill_addr = 0;
    logic           o_req_ready, o_wb_rd_en, o_fill_we, o_done, o_err;
    logic [BW-1:0]  o_wb_rd_beat, o_fill_beat;
    logic [63:0]    i_wb_rd_data = 0, o_fill_data;
    logic [IDW-1:0] o_awid, o_arid;
    logic [IDW-1:0] i_bid = 0, i_rid = 0;
    logic [31:0]    o_awaddr, o_araddr;
    logic [7:0]     o_awlen, o_arlen, o_wstrb;
    logic [2:0]     o_awsize, o_arsize;
    logic [1:0]     o_awburst, o_arburst;
    logic           o_awvalid, o_wlast, o_wvalid, o_bready, o_arvalid, o_rready;
    logic           i_awready = 0, i_wready = 0, i_bvalid = 0, i_arready = 0;
    logic           i_rlast = 0, i_rvalid = 0;
    logic [63:0]    o_wdata, i_rdata = 0;
    logic [1:0]     i_bresp = 0, i_rresp = 0;

    cache_line_sequencer #(.ID_WIDTH(IDW), .LINE_BEATS(LB)) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_wb(i_req_wb), .i_req_wb_addr(i_req_wb_addr),
        .i_req_fill(i_req_fill), .i_req_fill_addr(i_req_fill_addr),
        .o_wb_rd_en(o_wb_rd_en), .o_wb_rd_beat(o_wb_rd_beat), .i_wb_rd_data(i_wb_rd_data),
        .o_fill_we(o_fill_we), .o_fill_beat(o_fill_beat), .o_fill_data(o_fill_data),
        .o_done(o_done), .o_err(o_err),
        .o_awid(o_awid), .o_awaddr(o_awaddr), .o_awlen(o_awlen), .o_awsize(o_awsize),
        .o_awburst(o_awburst), .o_awvalid(o_awvalid), .i_awready(i_awready),
        .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wlast(o_wlast), .o_wvalid(o_wvalid),
        .i_wready(i_wready),
        .i_bid(i_bid), .i_bresp(i_bresp), .i_bvalid(i_bvalid), .o_bready(o_bready),
        .o_arid(o_arid), .o_araddr(o_araddr), .o_arlen(o_arlen), .o_arsize(o_arsize),
        .o_arburst(o_arburst), .o_arvalid(o_arvalid), .i_arready(i_arready),
        .i_rid(i_rid), .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rlast(i_rlast),
        .i_rvalid(i_rvalid), .o_rready(o_rready)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct { bit last; logic [63:0] data; } wbeat_t;
    typedef struct { int beat; logic [63:0] data; } fbeat_t;

    logic [31:0] exp_aw_q[$];
    logic [31:0] exp_ar_q[$];
    wbeat_t      exp_w_q[$];
    fbeat_t      exp_fill_q[$];
    bit          exp_done_q[$];

    // Reference memory (updated when a request is issued) and the slave's own memory
    // (updated only by observed W handshakes); both start from the same contents.
    logic [63:0] ref_mem [logic [31:0]];
    logic [63:0] slv_mem [logic [31:0]];
    logic [63:0] arr [LB];

    function automatic logic [63:0] init_word(logic [31:0] a);
        return {a, a ^ 32'h5A5A_C3C3};
    endfunction
    function automatic logic [63:0] ref_rd(logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_word(a);
    endfunction
    function automatic logic [63:0] slv_rd(logic [31:0] a);
        if (slv_mem.exists(a)) return slv_mem[a];
        return init_word(a);
    endfunction

    int         cfg_aw_delay = 0, cfg_ar_delay = 0, cfg_gap_pct = 0;
    bit         cfg_w_toggle = 0;
    logic [1:0] cfg_bresp = 0, cfg_rresp = 0;
    int         cfg_rresp_idx = -1, cfg_rlast_idx = LB - 1;

    int          aw_cnt, ar_cnt, w_cnt, r_idx, done_cnt;
    bit          b_pending, wb_open, r_active, rd_pend, w_tog;
    int          rd_beat;
    logic [31:0] aw_base, r_base;
    bit          prev_awv, prev_wv, prev_arv;
    logic [31:0] prev_awaddr, prev_araddr;
    logic [63:0] prev_wdata;
    logic        prev_wlast;

    function automatic bit rnd_ok();
        return int'($urandom_range(0, 99)) >= cfg_gap_pct;
    endfunction

    task automatic slave_reset();
        aw_cnt = 0; ar_cnt = 0; w_cnt = 0; r_idx = 0;
        b_pending = 0; wb_open = 0; r_active = 0; rd_pend = 0; w_tog = 0;
        prev_awv = 0; prev_wv = 0; prev_arv = 0;
        exp_aw_q.delete(); exp_ar_q.delete(); exp_w_q.delete();
        exp_fill_q.delete(); exp_done_q.delete();
    endtask

    task automatic monitor();
        wbeat_t wb;
        fbeat_t fb;
        bit     e;
        if (prev_awv) begin
            chk("aw_valid_hold", 64'(o_awvalid), 64'd1);
            chk("aw_addr_hold", 64'(o_awaddr), 64'(prev_awaddr));
        end
        if (prev_wv) begin
            chk("w_valid_hold", 64'(o_wvalid), 64'd1);
            chk("w_data_hold", o_wdata, prev_wdata);
            chk("w_last_hold", 64'(o_wlast), 64'(prev_wlast));
        end
        if (prev_arv) begin
            chk("ar_valid_hold", 64'(o_arvalid), 64'd1);
            chk("ar_addr_hold", 64'(o_araddr), 64'(prev_araddr));
        end
        if (o_awvalid && i_awready) begin
            if (exp_aw_q.size() == 0) chk("aw_unexpected", 64'(o_awaddr), 64'hFFFF_FFFF_FFFF_FFFF);
            else chk("awaddr", 64'(o_awaddr), 64'(exp_aw_q.pop_front()));
            chk("aw_fields", {o_awid, o_awlen, o_awsize, o_awburst},
                {6'd0, 8'(LB - 1), 3'd3, 2'b01});
            aw_base = o_awaddr; w_cnt = 0; aw_cnt = 0; wb_open = 1;
        end
        if (o_wvalid && i_wready) begin
            if (exp_w_q.size() == 0) chk("w_unexpected", o_wdata, ~o_wdata);
            else begin
                wb = exp_w_q.pop_front();
                chk("wdata", o_wdata, wb.data);
                chk("wlast", 64'(o_wlast), 64'(wb.last));
            end
            chk("wstrb", 64'(o_wstrb), 64'hFF);
            slv_mem[aw_base + 32'(8 * w_cnt)] = o_wdata;
            w_cnt++;
            if (w_cnt == LB) b_pending = 1;
        end
        if (o_bready && i_bvalid) begin
            b_pending = 0; wb_open = 0;
        end
        if (o_arvalid) chk("ar_after_b", 64'(wb_open), 64'd0);
        if (o_arvalid && i_arready) begin
            if (exp_ar_q.size() == 0) chk("ar_unexpected", 64'(o_araddr), 64'hFFFF_FFFF_FFFF_FFFF);
            else chk("araddr", 64'(o_araddr), 64'(exp_ar_q.pop_front()));
            chk("ar_fields", {o_arid, o_arlen, o_arsize, o_arburst},
                {6'd0, 8'(LB - 1), 3'd3, 2'b01});
            r_active = 1; r_idx = 0; r_base = o_araddr; ar_cnt = 0;
        end
        if (o_rready && i_rvalid) begin
            r_idx++;
            if (r_idx == LB) r_active = 0;
        end
        if (o_fill_we) begin
            if (exp_fill_q.size() == 0) chk("fill_unexpected", 64'(o_fill_beat), 64'hFF);
            else begin
                fb = exp_fill_q.pop_front();
                chk("fill_beat", 64'(o_fill_beat), 64'(fb.beat));
                chk("fill_data", o_fill_data, fb.data);
            end
        end
        rd_pend = o_wb_rd_en;
        rd_beat = int'(o_wb_rd_beat);
        if (o_done) begin
            if (exp_done_q.size() == 0) chk("done_unexpected", 64'(o_done), 64'd0);
            else begin
                e = exp_done_q.pop_front();
                chk("done_err", 64'(o_err), 64'(e));
                chk("done_drained", 64'(exp_w_q.size() + exp_fill_q.size() +
                    exp_aw_q.size() + exp_ar_q.size()), 64'd0);
                $display("[TB] request %0d done, err=%0d (expected %0d)", done_cnt, o_err, e);
            end
            done_cnt++;
        end
        prev_awv = o_awvalid && !i_awready; prev_awaddr = o_awaddr;
        prev_arv = o_arvalid && !i_arready; prev_araddr = o_araddr;
        prev_wv  = o_wvalid && !i_wready;   prev_wdata  = o_wdata; prev_wlast = o_wlast;
    endtask

    task automatic drive();
        if (o_awvalid && aw_cnt >= cfg_aw_delay && rnd_ok()) i_awready = 1;
        else begin
            i_awready = 0;
            if (o_awvalid) aw_cnt++;
        end
        if (cfg_w_toggle) begin
            w_tog = !w_tog;
            i_wready = w_tog;
        end else i_wready = rnd_ok();
        i_bvalid = b_pending && (i_bvalid || rnd_ok());
        i_bresp  = cfg_bresp;
        if (o_arvalid && ar_cnt >= cfg_ar_delay && rnd_ok()) i_arready = 1;
        else begin
            i_arready = 0;
            if (o_arvalid) ar_cnt++;
        end
        i_rvalid = r_active && rnd_ok();
        if (i_rvalid) begin
            i_rdata = slv_rd(r_base + 32'(8 * r_idx));
            i_rresp = (r_idx == cfg_rresp_idx) ? cfg_rresp : 2'b00;
            i_rlast = (r_idx == cfg_rlast_idx);
        end else begin
            i_rdata = {$urandom, $urandom};
            i_rresp = 2'b00;
            i_rlast = 0;
        end
        i_wb_rd_data = rd_pend ? arr[rd_beat] : {$urandom, $urandom};
    endtask

    initial begin
        slave_reset();
        done_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst) slave_reset();
            else monitor();
            @(posedge clk);
            #1;
            drive();
        end
    end

    // Model of one request at line level: writeback updates memory first, then the refill reads it.
    task automatic issue(bit wb, logic [31:0] wa, bit fill, logic [31:0] fa);
        logic [31:0] wl, fl;
        bit          err;
        bit          acc;
        wl = wa & ~32'(LB * 8 - 1);
        fl = fa & ~32'(LB * 8 - 1);
        err = 0;
        if (wb) begin
            exp_aw_q.push_back(wl);
            for (int b = 0; b < LB; b++) begin
                exp_w_q.push_back('{last: (b == LB - 1), data: arr[b]});
                ref_mem[wl + 32'(8 * b)] = arr[b];
            end
            if (cfg_bresp != 2'b00) err = 1;
        end
        if (fill) begin
            exp_ar_q.push_back(fl);
            for (int b = 0; b < LB; b++)
                exp_fill_q.push_back('{beat: b, data: ref_rd(fl + 32'(8 * b))});
            if (cfg_rresp != 2'b00 && cfg_rresp_idx >= 0 && cfg_rresp_idx < LB) err = 1;
            if (cfg_rlast_idx != LB - 1) err = 1;
        end
        exp_done_q.push_back(err);
        @(posedge clk);
        #1;
        i_req_valid = 1; i_req_wb = wb; i_req_wb_addr = wa;
        i_req_fill = fill; i_req_fill_addr = fa;
        acc = 0;
        for (int c = 0; c < 200 && !acc; c++) begin
            @(negedge clk);
            acc = o_req_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) chk("accept_timeout", 64'd0, 64'd1);
        i_req_valid = 0; i_req_wb = $urandom; i_req_fill = $urandom;
        i_req_wb_addr = $urandom; i_req_fill_addr = $urandom;
    endtask

    task automatic wait_done();
        bit fin;
        fin = 0;
        for (int c = 0; c < 3000 && !fin; c++) begin
            @(posedge clk);
            #1;
            fin = (exp_done_q.size() == 0);
        end
        if (!fin) chk("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic clean_cfg();
        cfg_aw_delay = 0; cfg_ar_delay = 0; cfg_gap_pct = 0; cfg_w_toggle = 0;
        cfg_bresp = 0; cfg_rresp = 0; cfg_rresp_idx = -1; cfg_rlast_idx = LB - 1;
    endtask

    initial begin
        logic [63:0] pre [4];
        bit hit;
        pre[0] = 64'h1111_1111_1111_1111; pre[1] = 64'h2222_2222_2222_2222;
        pre[2] = 64'h3333_3333_3333_3333; pre[3] = 64'h4444_4444_4444_4444;
        clean_cfg();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 64'(o_req_ready), 64'd1);
        chk("rst_valids", {o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready,
            o_wb_rd_en, o_fill_we, o_done, o_err}, 64'd0);
        chk("rst_addrs", {o_awaddr, o_araddr}, 64'd0);
        chk("rst_data", o_wdata | o_fill_data, 64'd0);
        @(posedge clk);
        #1 rst = 0;

        // Fill only from a preloaded line; unaligned request address.
        for (int b = 0; b < LB; b++) begin
            ref_mem[32'h1220 + 32'(8 * b)] = pre[b];
            slv_mem[32'h1220 + 32'(8 * b)] = pre[b];
        end
        issue(0, 32'h0, 1, 32'h0000_1234);
        wait_done();

        // Writeback then refill to a different line.
        for (int b = 0; b < LB; b++) arr[b] = {8'hA0 + 8'(b), 56'h0123_4567_89AB_CD};
        issue(1, 32'h2000, 1, 32'h3000);
        wait_done();

        // Backpressure on every channel; refill reads back the line just written.
        cfg_aw_delay = 5; cfg_w_toggle = 1; cfg_ar_delay = 3;
        for (int b = 0; b < LB; b++) arr[b] = {$urandom, $urandom};
        issue(1, 32'h3000, 1, 32'h3000);
        wait_done();
        clean_cfg();

        // Write response error still performs the refill; next clean request clears the flag.
        cfg_bresp = 2'b10;
        issue(1, 32'h2020, 1, 32'h2040);
        wait_done();
        clean_cfg();
        issue(0, 32'h0, 1, 32'h2020);
        wait_done();

        // Early rlast on beat 2 of 4.
        cfg_rlast_idx = 2;
        issue(0, 32'h0, 1, 32'h5000);
        wait_done();
        clean_cfg();

        // Reset during the second writeback beat.
        for (int b = 0; b < LB; b++) arr[b] = {$urandom, $urandom};
        issue(1, 32'h4000, 1, 32'h5000);
        hit = 0;
        for (int c = 0; c < 200 && !hit; c++) begin
            @(posedge clk);
            #1;
            hit = (w_cnt == 1) && o_wvalid;
        end
        chk("rst_mid_reach", 64'(hit), 64'd1);
        rst = 1;
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_mid_wvalid", 64'(o_wvalid), 64'd0);
        chk("rst_mid_ready", 64'(o_req_ready), 64'd1);
        chk("rst_mid_others", {o_awvalid, o_bready, o_arvalid, o_done}, 64'd0);
        for (int b = 0; b < LB; b++) begin
            ref_mem.delete(32'h4000 + 32'(8 * b));
            slv_mem.delete(32'h4000 + 32'(8 * b));
        end
        issue(0, 32'h0, 1, 32'h4000);
        wait_done();

        // No-op request completes in the cycle after acceptance with no AXI traffic.
        issue(0, 32'h0, 0, 32'h0);
        chk("nop_done_next", 64'(o_done), 64'd1);
        chk("nop_no_axi", {o_awvalid, o_arvalid, o_wvalid}, 64'd0);
        wait_done();

        // Randomized requests over a small set of overlapping lines.
        for (int n = 0; n < 25; n++) begin
            bit wb, fl;
            cfg_gap_pct  = int'($urandom_range(0, 60));
            cfg_aw_delay = int'($urandom_range(0, 3));
            cfg_ar_delay = int'($urandom_range(0, 3));
            cfg_w_toggle = ($urandom_range(0, 3) == 0);
            cfg_bresp    = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            cfg_rresp    = 2'($urandom_range(1, 3));
            cfg_rresp_idx = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, LB - 1)) : -1;
            cfg_rlast_idx = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, LB - 1)) : LB - 1;
            for (int b = 0; b < LB; b++) arr[b] = {$urandom, $urandom};
            wb = $urandom; fl = $urandom;
            issue(wb, 32'h8000 + 32'($urandom_range(0, 7) * 32) + 32'($urandom_range(0, 31)),
                  fl, 32'h8000 + 32'($urandom_range(0, 7) * 32) + 32'($urandom_range(0, 31)));
            wait_done();
        end

        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end
endmodule
